// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
//   XLEN             - datapath width (32)
//   RESET_PC_DEFAULT - default first fetch address
//   BUF_DEPTH        - instruction buffer depth: 2 when FETCH_CTRL_SKID_BUF_EN
//                      is defined, otherwise 1
//   fetch_state_t    - controller FSM encoding (IDLE, REQ, WAIT, FLUSH)
//   fetch_entry_t    - buffer entry {instr, pc}
//   fetch_dbg_t      - debug view of the controller {state, buffer count}
//   align_pc()       - forces the two low address bits to zero
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_CTRL_SKID_BUF_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef struct packed {
        fetch_state_t state;
        logic [1:0]   count;
    } fetch_dbg_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the redirect input, the instruction memory port and
// the decode-side instruction port of the fetch controller.
//   master modport - the fetch controller
//   slave  modport - the environment (branch unit, memory, decode)
//
// Handshakes: a memory request transfers on a cycle where imem_req && imem_gnt;
// imem_addr holds steady while imem_req is high and not yet granted (a redirect
// is the only exception). imem_rvalid returns one word per grant, no earlier
// than the cycle after the grant. A decode entry transfers on a cycle where
// instr_valid && instr_ready; instr/instr_pc are stable while instr_valid waits.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: small synchronous FIFO holding fetched {instr, pc} entries.
//   clk, rst     - clock, asynchronous active-high reset
//   flush        - empties the FIFO; wins over push and pop
//   push / din   - write an entry (caller guarantees space)
//   pop          - drop the head entry (caller guarantees non-empty)
//   dout         - head entry
//   full, empty, count - occupancy
// DEPTH is 1 or 2. The head always lives in slot 0, so dout needs no read mux.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem [DEPTH];
    logic [1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    generate
        if (DEPTH == 1) begin : g_depth1
            // Push with a simultaneous pop simply replaces the single entry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[0] <= '0;
                end else if (!flush && push) begin
                    mem[0] <= din;
                end
            end
        end else begin : g_depth2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[0] <= '0;
                    mem[1] <= '0;
                end else if (!flush) begin
                    if (pop) begin
                        // Shift toward the head; a concurrent push lands behind
                        // whatever survives so order is preserved.
                        mem[0] <= (push && cnt == 2'd1) ? din : mem[1];
                        if (push && cnt == 2'd2) begin
                            mem[1] <= din;
                        end
                    end else if (push) begin
                        if (cnt == 2'd0) begin
                            mem[0] <= din;
                        end else begin
                            mem[1] <= din;
                        end
                    end
                end
            end
        end
    endgenerate

    assign dout  = mem[0];
    assign full  = (cnt == 2'(DEPTH));
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. Walks the PC, issues one
// instruction memory request at a time, buffers returned words with their PC
// for decode, and handles branch redirects by flushing and discarding the
// in-flight response.
//   clk    - clock
//   n_rst  - asynchronous reset, active HIGH (name kept from the codebase)
//   bus    - fetch_ctrl_if.master: redirect, imem request/response, decode port
//   dbg    - current FSM state and buffer occupancy
// Parameter RESET_PC: first fetch address after reset.
// Macro FETCH_CTRL_SKID_BUF_EN selects a 2-entry buffer (default 1 entry).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          n_rst,
    fetch_ctrl_if.master  bus,
    output fetch_dbg_t    dbg
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;   // address of the outstanding request
    logic            imem_req_c;
    logic            grant;
    logic            push;
    logic            pop;
    logic            free;
    logic            buf_full, buf_empty;
    logic [1:0]      buf_count;
    fetch_entry_t    head;

    assign pop   = !buf_empty && bus.instr_ready;
    assign grant = imem_req_c && bus.imem_gnt;
    // A slot is free if the buffer has room now or the head leaves this cycle;
    // no request is outstanding while in REQ, so that is all the accounting.
    assign free  = !buf_full || pop;

    // State register
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC and outstanding-address registers; redirect overrides increment.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (bus.redirect_valid) begin
                pc <= align_pc(bus.redirect_pc);
            end else if (grant) begin
                pc <= pc + 32'd4;
            end
            if (grant) begin
                req_addr <= pc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ:   if (grant) state_nxt = bus.redirect_valid ? FLUSH : WAIT;
            // A redirect coinciding with the response drops the word and
            // needs no FLUSH since nothing is left in flight.
            WAIT:  if (bus.imem_rvalid)         state_nxt = REQ;
                   else if (bus.redirect_valid) state_nxt = FLUSH;
            // A response retires the stale request even if another redirect
            // arrives with it; otherwise keep waiting for it.
            FLUSH: if (bus.imem_rvalid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_c = 1'b0;
        push       = 1'b0;
        case (state)
            REQ:     imem_req_c = free;
            WAIT:    push       = bus.imem_rvalid && !bus.redirect_valid;
            default: ;
        endcase
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (n_rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop && !bus.redirect_valid),
        .din   ('{instr: bus.imem_rdata, pc: req_addr}),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign bus.imem_req    = imem_req_c;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = !buf_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

    assign dbg.state = state;
    assign dbg.count = buf_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed bench for fetch_ctrl with a
// transaction-level reference model (expected PC, outstanding flag, drop flag
// and a queue of expected decode PCs). A second instance with
// RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_ctrl;
    import fetch_pkg::*;

`ifdef FETCH_CTRL_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();
    fetch_ctrl_if bus2();
    fetch_dbg_t   dbg, dbg2;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .n_rst(rst), .bus(bus), .dbg(dbg)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .n_rst(rst), .bus(bus2), .dbg(dbg2)
    );

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];      // expected PCs waiting in the decode buffer
    logic [31:0] m_pc;          // expected next fetch address
    logic        m_idle;        // one-cycle post-reset idle
    logic        m_out;         // request outstanding
    logic        m_drop;        // outstanding response must be discarded
    logic [31:0] m_out_addr;
    int          m_cnt;         // cycles until the responder fires rvalid
    int          lat_mode;      // 0 = random 1..3, else fixed latency

    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] req_addrs[$];  // granted addresses as seen on the bus
    logic [31:0] pop_pcs[$];    // instr_pc of accepted entries
    logic [31:0] g2_q[$];       // requested addresses of the wrap instance
    logic        m2_rv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.instr_ready    = 1'b0;
        bus2.imem_rvalid   = 1'b0;
        #1;
        chk("rst_req",   32'(bus.imem_req),    32'd0);
        chk("rst_addr",  bus.imem_addr,        32'h0000_0000);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr,            32'd0);
        chk("rst_ipc",   bus.instr_pc,         32'd0);
        chk("rst_state", 32'(dbg.state),       32'(IDLE));
        chk("rst_addr2", bus2.imem_addr,       32'hFFFF_FFFC);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        req_addrs.delete();
        pop_pcs.delete();
        g2_q.delete();
        m_pc   = 32'h0000_0000;
        m_idle = 1'b1;
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_cnt  = 0;
        m2_rv  = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic gnt,
                        input logic rdy, input logic force_rv);
        logic rv, pop, exp_req, granted;
        @(negedge clk);
        rv = force_rv || (m_out && m_cnt == 0);
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.imem_gnt       = gnt;
        bus.instr_ready    = rdy;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = mem_word(m_out_addr);
        bus2.imem_rvalid   = m2_rv;
        #1;
        pop     = (exp_q.size() > 0) && rdy;
        exp_req = !m_idle && !m_out && ((exp_q.size() < DEPTH) || pop);
        chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() > 0));
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
        if (exp_q.size() > 0) begin
            chk("instr_pc", bus.instr_pc, exp_q[0]);
            chk("instr", bus.instr, mem_word(exp_q[0]));
        end
        s_req  = bus.imem_req;
        s_addr = bus.imem_addr;
        if (bus.imem_req && gnt) req_addrs.push_back(bus.imem_addr);
        if (bus.instr_valid && rdy && !redir) pop_pcs.push_back(bus.instr_pc);
        if (bus2.imem_req) g2_q.push_back(bus2.imem_addr);
        m2_rv = bus2.imem_req;

        granted = exp_req && gnt;
        if (pop && !redir) void'(exp_q.pop_front());
        if (rv && m_out) begin
            if (!m_drop && !redir) exp_q.push_back(m_out_addr);
            m_out  = 1'b0;
            m_drop = 1'b0;
        end
        if (m_out && m_cnt > 0) m_cnt--;
        if (redir) begin
            exp_q.delete();
            if (m_out) m_drop = 1'b1;
        end
        if (granted) begin
            m_out      = 1'b1;
            m_drop     = redir;
            m_out_addr = m_pc;
            m_cnt      = ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode) - 1;
            m_pc       = m_pc + 32'd4;
        end
        if (redir) m_pc = {tgt[31:2], 2'b00};
        m_idle = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.instr_ready    = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'd0;
        bus2.imem_gnt       = 1'b1;
        bus2.imem_rvalid    = 1'b0;
        bus2.imem_rdata     = 32'h0000_0013;
        bus2.instr_ready    = 1'b1;
        m_out_addr = 32'd0;
        lat_mode   = 1;

        // Straight-line fetch, plus a late rvalid in the idle cycle.
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("seq_a0", (req_addrs.size() > 0) ? req_addrs[0] : 32'hxxxx_xxxx, 32'h0);
        chk("seq_a1", (req_addrs.size() > 1) ? req_addrs[1] : 32'hxxxx_xxxx, 32'h4);
        chk("seq_a2", (req_addrs.size() > 2) ? req_addrs[2] : 32'hxxxx_xxxx, 32'h8);
        chk("seq_p0", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hxxxx_xxxx, 32'h0);
        chk("seq_p1", (pop_pcs.size() > 1) ? pop_pcs[1] : 32'hxxxx_xxxx, 32'h4);
        chk("seq_p2", (pop_pcs.size() > 2) ? pop_pcs[2] : 32'hxxxx_xxxx, 32'h8);
        chk("wrap_a0", (g2_q.size() > 0) ? g2_q[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        chk("wrap_a1", (g2_q.size() > 1) ? g2_q[1] : 32'hxxxx_xxxx, 32'h0000_0000);

        // Grant withheld for three cycles.
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            chk("stall_req", 32'(s_req), 32'd1);
            chk("stall_addr", s_addr, 32'h0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("gnt4_req", 32'(s_req), 32'd1);
        chk("gnt4_addr", s_addr, 32'h4);

        // Decode stall: buffer fills to its depth, then fetch resumes.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("full_grants", 32'(req_addrs.size()), 32'(DEPTH));
        chk("full_req", 32'(s_req), 32'd0);
        req_addrs.delete();
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("resume_addr", (req_addrs.size() > 0) ? req_addrs[0] : 32'hxxxx_xxxx, 32'(DEPTH * 4));

        // Redirect while waiting for the response.
        lat_mode = 2;
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("redir_req", 32'(s_req), 32'd1);
        chk("redir_addr", s_addr, 32'h100);
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("redir_pop", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hxxxx_xxxx, 32'h100);

        // Reset pulsed mid-transaction with a filled buffer.
        lat_mode = 1;
        do_reset();
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        chk("restart_idle", 32'(s_req), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("restart_req", 32'(s_req), 32'd1);
        chk("restart_addr", s_addr, 32'h0);

        // Random traffic against the model.
        lat_mode = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-high reset; the port keeps the codebase name despite the polarity.
REQ-004 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-005 redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 2'b00.
REQ-006 imem_req  output  1  instruction memory request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-009 imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr_valid  output  1  instr and instr_pc hold a valid entry.
REQ-012 instr  output  32  instruction to decode.
REQ-013 instr_pc  output  32  PC of instr.
REQ-014 instr_ready  input  1  decode accepts; entry pops when instr_valid && instr_ready.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, FLUSH; encoding is fetch_state_t.
REQ-016 IDLE lasts exactly one cycle after reset release, then goes to REQ.
REQ-017 REQ drives imem_req=1 and imem_addr=pc only while the buffer has a free slot, counting the outstanding request; otherwise imem_req=0 and the FSM stays in REQ.
REQ-018 On grant in REQ: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), record the granted address, go to WAIT.
REQ-019 At most one request is outstanding; imem_req=0 in WAIT and FLUSH.
REQ-020 In WAIT, imem_rvalid pushes {imem_rdata, recorded address} into the buffer and the FSM returns to REQ.
REQ-021 Response-to-output latency: rvalid in cycle N gives instr_valid=1 in cycle N+1 when the buffer was empty.
REQ-022 Redirect in any state: pc <= {redirect_pc[31:2],2'b00} and the buffer is flushed; instr_valid=0 next cycle.
REQ-023 Redirect in WAIT, or in REQ with same-cycle grant, goes to FLUSH; FLUSH discards the next imem_rvalid and then goes to REQ.
REQ-024 Redirect in REQ without grant stays in REQ; imem_addr takes the new pc next cycle.
REQ-025 Redirect in FLUSH updates pc again and stays in FLUSH.
REQ-026 Redirect coincident with imem_rvalid in WAIT: data dropped, go to REQ.
REQ-027 Redirect has priority over a same-cycle pop; the pop is discarded.
REQ-028 While imem_req && !imem_gnt, imem_addr is stable unless a redirect occurs.
REQ-029 Buffer full plus same-cycle pop and push is legal; occupancy is unchanged and order is preserved.

Reset
REQ-030 During n_rst=1: state=IDLE, pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-031 Reset asserted mid-transaction abandons it; a late imem_rvalid after reset release, while in IDLE, is ignored.

Configuration
REQ-032 Macro FETCH_CTRL_SKID_BUF_EN defined: instruction buffer depth is 2, so fetch continues during a one-entry decode stall.
REQ-033 Macro undefined: depth is 1; a new request issues only when the buffer is empty, or is being popped that cycle with no request outstanding.

Structure
REQ-034 Package fetch_pkg holds fetch_state_t, XLEN=32, RESET_PC_DEFAULT and the buffer entry struct {instr, pc}.
REQ-035 Sub-module fetch_buf is a synchronous FIFO with depth 1 or 2, flush, push, pop, full, empty and count; fetch_ctrl instantiates it once.

Verification
REQ-036 Reset release, gnt=1, rvalid 1 cycle after grant, ready=1: imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches each word in order.
REQ-037 instr_ready=0 with skid enabled: exactly 2 entries captured, imem_req drops; ready=1 resumes at 0x8.
REQ-038 redirect_pc=0x0000_0103 in WAIT: the pending rdata is discarded, next imem_addr=0x100, and the first instr_pc is 0x100.
REQ-039 imem_gnt held 0 for 3 cycles: imem_req and imem_addr stay stable; grant on cycle 4 advances pc by 4.
REQ-040 RESET_PC=32'hFFFF_FFFC: the second fetch address is 0x0000_0000.
REQ-041 n_rst pulsed during WAIT: outputs return to reset values immediately, and fetch restarts at RESET_PC two cycles after release.
